// File: rtl/frame_requester.sv
// Frame requester: wraps a command in an A5/cmd/len/payload/crc frame, sends it
// byte by byte through a UART transmitter and waits for a one-byte reply.
module frame_requester #(
    parameter int unsigned MAX_PAYLOAD  = 16,
    parameter int unsigned TIMEOUT_CLKS = 2700000,
    parameter bit          WAIT_READY   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_cmd,
    input  logic [7:0]               req_len,
    input  logic [8*MAX_PAYLOAD-1:0] req_payload_flat,
    output logic                     resp_valid,
    output logic [7:0]               resp_byte,
    output logic [1:0]               resp_status,
    output logic                     link_up,
    output logic                     tx_dv,
    output logic [7:0]               tx_byte,
    input  logic                     tx_active,
    input  logic                     tx_done,
    input  logic                     rx_dv,
    input  logic [7:0]               rx_byte
);

    localparam int unsigned PW = 8 * MAX_PAYLOAD;
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS) + 1;

    localparam logic [7:0] MAGIC      = 8'hA5;
    localparam logic [7:0] READY_BYTE = 8'h52;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BAD_LEN = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RESP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_len;
    logic [PW-1:0]   r_payload;
    logic [7:0]      r_crc;
    logic [7:0]      r_idx;
    logic [TW-1:0]   r_timer;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [7:0]      r_resp_byte;
    logic [1:0]      r_resp_status;
    logic            r_link_up;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;

    logic            w_accept;
    logic            w_bad_len;
    logic [7:0]      w_in_crc;
    logic [7:0]      w_pl_sel;
    logic [7:0]      w_pl_byte;
    logic [7:0]      w_cur_byte;
    logic            w_last_sent;

    assign w_accept    = r_req_ready & req_valid;
    assign w_bad_len   = (32'(req_len) > MAX_PAYLOAD);
    assign w_last_sent = ({1'b0, r_idx} == ({1'b0, r_len} + 9'd4));

    // CRC is computed from the live inputs so it is ready the moment they are captured
    always_comb begin
        w_in_crc = req_cmd ^ req_len;
        for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            if (32'(k) < 32'(req_len)) begin
                w_in_crc = w_in_crc ^ req_payload_flat[k*8 +: 8];
            end
        end
    end

    // Byte index map: 0 magic, 1 cmd, 2 len, 3..len+2 payload, len+3 crc
    always_comb begin
        w_pl_sel  = r_idx - 8'd3;
        w_pl_byte = 8'h00;
        for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            if (w_pl_sel == 8'(k)) begin
                w_pl_byte = r_payload[k*8 +: 8];
            end
        end
        if (r_idx == 8'd0) begin
            w_cur_byte = MAGIC;
        end else if (r_idx == 8'd1) begin
            w_cur_byte = r_cmd;
        end else if (r_idx == 8'd2) begin
            w_cur_byte = r_len;
        end else if ({1'b0, r_idx} == ({1'b0, r_len} + 9'd3)) begin
            w_cur_byte = r_crc;
        end else begin
            w_cur_byte = w_pl_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= WAIT_READY ? S_WAIT_RDY : S_IDLE;
            r_link_up     <= ~WAIT_READY;
            r_cmd         <= 8'h00;
            r_len         <= 8'h00;
            r_payload     <= '0;
            r_crc         <= 8'h00;
            r_idx         <= 8'h00;
            r_timer       <= '0;
            r_req_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_byte   <= 8'h00;
            r_resp_status <= ST_OK;
            r_tx_dv       <= 1'b0;
            r_tx_byte     <= 8'h00;
        end else begin
            r_tx_dv      <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_WAIT_RDY: begin
                    if (rx_dv && (rx_byte == READY_BYTE)) begin
                        r_link_up   <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd     <= req_cmd;
                        r_len     <= req_len;
                        r_payload <= req_payload_flat;
                        r_crc     <= w_in_crc;
                        if (w_bad_len) begin
                            r_resp_valid  <= 1'b1;
                            r_resp_byte   <= 8'h00;
                            r_resp_status <= ST_BAD_LEN;
                        end else begin
                            r_req_ready <= 1'b0;
                            // Magic goes out straight away when the transmitter is free
                            if (!tx_active) begin
                                r_tx_dv   <= 1'b1;
                                r_tx_byte <= MAGIC;
                                r_idx     <= 8'd1;
                                r_state   <= S_WAIT_TX;
                            end else begin
                                r_idx   <= 8'd0;
                                r_state <= S_SEND;
                            end
                        end
                    end
                end
                S_SEND: begin
                    if (!tx_active) begin
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= w_cur_byte;
                        r_idx     <= r_idx + 8'd1;
                        r_state   <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        if (w_last_sent) begin
                            r_timer <= '0;
                            r_state <= S_WAIT_RESP;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    // A reply arriving on the timeout cycle still wins
                    if (rx_dv) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_byte   <= rx_byte;
                        r_resp_status <= ST_OK;
                        r_req_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_timer == TW'(TIMEOUT_CLKS - 1)) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_byte   <= 8'h00;
                        r_resp_status <= ST_TIMEOUT;
                        r_req_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= WAIT_READY ? S_WAIT_RDY : S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_byte   = r_resp_byte;
    assign resp_status = r_resp_status;
    assign link_up     = r_link_up;
    assign tx_dv       = r_tx_dv;
    assign tx_byte     = r_tx_byte;

endmodule
